// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//
// Contents:
//   mul_state_t        three-state controller encoding (IDLE / RUN / DONE)
//   MUL_DEFAULT_WIDTH  operand width used when the top is not parameterised
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_t;

  localparam int MUL_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/mul_operand_abs.sv
// Combinational two's-complement magnitude of one operand.
// It is used only by the signed build of seq_multiplier (MUL_SIGNED_EN).
//
// Ports:
//   i_value  in   WIDTH  two's-complement operand
//   o_mag    out  WIDTH  |i_value|, interpreted as unsigned
//   o_sign   out  1      sign bit of i_value
module mul_operand_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  output logic [WIDTH-1:0] o_mag,
  output logic             o_sign
);

  // The most negative value negates to itself. Read as unsigned, that is
  // exactly 2^(WIDTH-1), so it needs no special handling.
  assign o_sign = i_value[WIDTH-1];
  assign o_mag  = o_sign ? -i_value : i_value;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// It uses a start/busy/done handshake, a clock enable and early termination.
// The operation ends as soon as the remaining multiplier or the shifted
// multiplicand becomes zero.
//
// Optional feature: define MUL_SIGNED_EN to add the sgn port.
// With sgn=1, the unit multiplies the operand magnitudes, then negates the
// result on the edge that raises done.
//
// Ports:
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset
//   ena    in   1        clock enable; 0 freezes all state
//   start  in   1        launch request; honoured only in IDLE or DONE
//   a      in   WIDTH    multiplier operand
//   b      in   WIDTH    multiplicand operand
//   sgn    in   1        signed mode (MUL_SIGNED_EN builds only)
//   p      out  2*WIDTH  product; valid while done=1
//   busy   out  1        operation in progress
//   done   out  1        result ready; held until the next accepted start
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MUL_SIGNED_EN
  input  logic               sgn,
`endif
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  mul_state_t         r_state;
  mul_state_t         w_stateNext;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_p;
  logic               w_accept;
  logic               w_terminate;
  logic [WIDTH-1:0]   w_loadA;
  logic [WIDTH-1:0]   w_loadB;
  logic [2*WIDTH-1:0] w_pFinal;

`ifdef MUL_SIGNED_EN
  logic             r_neg;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic             w_signA;
  logic             w_signB;

  mul_operand_abs #(.WIDTH(WIDTH)) u_absA (
    .i_value (a),
    .o_mag   (w_absA),
    .o_sign  (w_signA)
  );

  mul_operand_abs #(.WIDTH(WIDTH)) u_absB (
    .i_value (b),
    .o_mag   (w_absB),
    .o_sign  (w_signB)
  );

  assign w_loadA = sgn ? w_absA : a;
  assign w_loadB = sgn ? w_absB : b;

  // The result sign is fixed at load time.
  // It is applied to the magnitude product only on the terminating edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else if (ena && w_accept) begin
      r_neg <= sgn & (w_signA ^ w_signB);
    end
  end

  assign w_pFinal = r_neg ? -r_p : r_p;
`else
  assign w_loadA  = a;
  assign w_loadB  = b;
  assign w_pFinal = r_p;
`endif

  assign w_accept    = start && ((r_state == MUL_IDLE) || (r_state == MUL_DONE));
  assign w_terminate = (r_mplr == '0) || (r_mcand == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MUL_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; ena=0 holds the current state
  always_comb begin
    w_stateNext = r_state;
    if (ena) begin
      case (r_state)
        MUL_IDLE: if (w_accept)    w_stateNext = MUL_RUN;
        MUL_RUN:  if (w_terminate) w_stateNext = MUL_DONE;
        MUL_DONE: if (w_accept)    w_stateNext = MUL_RUN;
        default:                   w_stateNext = MUL_IDLE;
      endcase
    end
  end

  // Status outputs are decoded directly from the state register,
  // so an asynchronous reset clears them without a clock.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      MUL_RUN:  busy = 1'b1;
      MUL_DONE: done = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: load on accept, then one shift-add step per enabled RUN cycle.
  // The mcand register is twice the operand width, so the accumulation
  // cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mplr  <= '0;
      r_mcand <= '0;
      r_p     <= '0;
    end else if (ena) begin
      if (w_accept) begin
        r_mplr  <= w_loadA;
        r_mcand <= {{WIDTH{1'b0}}, w_loadB};
        r_p     <= '0;
      end else if (r_state == MUL_RUN) begin
        if (w_terminate) begin
          r_p <= w_pFinal;
        end else begin
          if (r_mplr[0]) begin
            r_p <= r_p + r_mcand;
          end
          r_mplr  <= r_mplr >> 1;
          r_mcand <= r_mcand << 1;
        end
      end
    end
  end

  assign p = r_p;

endmodule
